tcam_lookup_ctrl: RTL and testbench

Front-end controller for the TCAM routing memory stage. Arbitrates table-programming requests (entry write, flush) against packet lookup requests and drives the memory stage's control, address, data and packet-ID inputs. Tracks the memory stage's compare/read cadence with a mirrored phase machine. Captures the returned destination ID into a 2-entry response buffer with valid/ready handshake toward the router.

---
 rtl/tcam_lookup_ctrl_if.sv | 22 ++
 rtl/tcam_lookup_ctrl.sv | 110 +++++++++++
 tb/tb_tcam_lookup_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/tcam_lookup_ctrl_if.sv
// tcam_lookup_ctrl_if: config, lookup-request and response channels between the router and the TCAM controller.
interface tcam_lookup_ctrl_if #(
   parameter int ID_WIDTH = 4,
   parameter int BITS = 2*ID_WIDTH,
   parameter int ADDR_W = 4
);
   logic                cfg_valid, cfg_ready, cfg_flush;
   logic [ADDR_W-1:0]   cfg_addr;
   logic [BITS-1:0]     cfg_data, cfg_mask;
   logic                req_valid, req_ready;
   logic [ID_WIDTH-1:0] req_id;
   logic                rsp_valid, rsp_ready;
   logic [ID_WIDTH-1:0] rsp_dst;
   modport master (
      output cfg_valid, cfg_flush, cfg_addr, cfg_data, cfg_mask, req_valid, req_id, rsp_ready,
      input  cfg_ready, req_ready, rsp_valid, rsp_dst
   );
   modport slave (
      input  cfg_valid, cfg_flush, cfg_addr, cfg_data, cfg_mask, req_valid, req_id, rsp_ready,
      output cfg_ready, req_ready, rsp_valid, rsp_dst
   );
endinterface

// File: rtl/tcam_lookup_ctrl.sv
// tcam_lookup_ctrl: arbitrates TCAM programming vs lookups, mirrors the compare/read phase, buffers results.
// Defining TCAM_CTRL_STATS_EN adds saturating stat_lookups/stat_miss counters.
module tcam_lookup_ctrl #(
   parameter int ID_WIDTH = 4,
   parameter int BITS = 2*ID_WIDTH,
   parameter int ADDR_W = 4,
   parameter int CAP_DLY = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   tcam_lookup_ctrl_if.slave   bus,
   output logic                CS,
   output logic                WR,
   output logic                FLUSH,
   output logic                VBE,
   output logic                DCS,
   output logic                VBI,
   output logic [ADDR_W-1:0]   Addr_In,
   output logic [BITS-1:0]     Data_In,
   output logic [BITS-1:0]     Mask_In,
   output logic [ID_WIDTH-1:0] PacketID_In,
   input  logic [ID_WIDTH-1:0] DstID_In
`ifdef TCAM_CTRL_STATS_EN
   ,
   output logic [15:0]         stat_lookups,
   output logic [15:0]         stat_miss
`endif
);
   localparam int P = 2 + CAP_DLY;
   typedef enum logic [1:0] {PH_IDLE, PH_CMP, PH_RD} ph_t;
   typedef enum logic [1:0] {S_RUN, S_WRITE, S_FLUSH, S_DRAIN} st_t;
   ph_t                 m_ph, ph_nxt;
   st_t                 state;
   logic [P-1:0]        pipe;
   logic [ID_WIDTH-1:0] buf_q [2];
   logic                wr_ptr, rd_ptr;
   logic [1:0]          count;
   logic [2:0]          occ;
   logic                push, pop, cfg_go, req_go, wr_go;
   // occ counts buffered results plus lookups still travelling toward capture
   always_comb begin
      ph_nxt = (m_ph == PH_CMP) ? PH_RD : (!WR && !FLUSH) ? PH_CMP : PH_IDLE;
      occ = {1'b0, count};
      for (int i = 0; i < P; i++) occ = occ + 3'(pipe[i]);
   end
   assign push = pipe[P-1];
   assign pop = bus.rsp_valid && bus.rsp_ready;
   assign bus.rsp_valid = count != 2'd0;
   assign bus.rsp_dst = buf_q[rd_ptr];
   assign cfg_go = CS && state == S_RUN && bus.cfg_valid && pipe == '0;
   assign req_go = CS && state == S_RUN && !bus.cfg_valid && bus.req_valid && ph_nxt == PH_CMP && occ < 3'd2;
   assign wr_go = cfg_go && !bus.cfg_flush;
   assign bus.cfg_ready = cfg_go;
   assign bus.req_ready = req_go;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_ph <= PH_IDLE;
         state <= S_RUN;
         pipe <= '0;
         CS <= 1'b0;
         WR <= 1'b0;
         FLUSH <= 1'b0;
         VBE <= 1'b0;
         DCS <= 1'b0;
         VBI <= 1'b0;
         Addr_In <= '0;
         Data_In <= '0;
         Mask_In <= '0;
         PacketID_In <= '0;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count <= 2'd0;
      end else begin
         m_ph <= ph_nxt;
         CS <= 1'b1;
         pipe <= {pipe[P-2:0], req_go};
         state <= cfg_go ? (bus.cfg_flush ? S_FLUSH : S_WRITE) :
                  (state == S_WRITE || state == S_FLUSH) ? S_DRAIN : S_RUN;
         WR <= wr_go;
         VBE <= wr_go;
         DCS <= wr_go;
         VBI <= wr_go;
         FLUSH <= cfg_go && bus.cfg_flush;
         Addr_In <= wr_go ? bus.cfg_addr : '0;
         Data_In <= wr_go ? bus.cfg_data : '0;
         Mask_In <= wr_go ? bus.cfg_mask : '0;
         if (req_go) PacketID_In <= bus.req_id;
         if (push) begin
            buf_q[wr_ptr] <= DstID_In;
            wr_ptr <= !wr_ptr;
         end
         if (pop) rd_ptr <= !rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
`ifdef TCAM_CTRL_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         stat_lookups <= '0;
         stat_miss <= '0;
      end else if (FLUSH) begin
         stat_lookups <= '0;
         stat_miss <= '0;
      end else if (push) begin
         if (stat_lookups != 16'hFFFF) stat_lookups <= stat_lookups + 16'd1;
         if (DstID_In == '0 && stat_miss != 16'hFFFF) stat_miss <= stat_miss + 16'd1;
      end
`endif
endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// tb_tcam_lookup_ctrl: directed checks of config, lookup latency, buffering, priority and reset.
module tb_tcam_lookup_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic CS, WR, FLUSH, VBE, DCS, VBI;
   logic [3:0] Addr_In, PacketID_In, dst_q;
   logic [7:0] Data_In, Mask_In;
   int checks = 0;
   int errors = 0;
   bit ok;
`ifdef TCAM_CTRL_STATS_EN
   logic [15:0] stat_lookups, stat_miss;
`endif
   tcam_lookup_ctrl_if #(.ID_WIDTH(4), .BITS(8), .ADDR_W(4)) bus ();
   tcam_lookup_ctrl #(.ID_WIDTH(4), .BITS(8), .ADDR_W(4), .CAP_DLY(1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .CS(CS), .WR(WR), .FLUSH(FLUSH), .VBE(VBE), .DCS(DCS), .VBI(VBI),
      .Addr_In(Addr_In), .Data_In(Data_In), .Mask_In(Mask_In),
      .PacketID_In(PacketID_In), .DstID_In(dst_q)
`ifdef TCAM_CTRL_STATS_EN
      , .stat_lookups(stat_lookups), .stat_miss(stat_miss)
`endif
   );
   always #5 clk = ~clk;
   // memory-stage model: result registered from the packet ID presented during compare/read
   function automatic logic [3:0] route(input logic [3:0] id);
      case (id)
         4'd5: return 4'hA;
         4'd1: return 4'h3;
         4'd2: return 4'h6;
         4'd3: return 4'h9;
         default: return 4'h0;
      endcase
   endfunction
   always @(posedge clk) dst_q <= route(PacketID_In);
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_req(input logic [3:0] id, input int max, output bit acc);
      bus.req_valid = 1'b1;
      bus.req_id = id;
      acc = 1'b0;
      for (int i = 0; i < max && !acc; i++) begin
         #1;
         acc = bus.req_ready;
         step();
      end
      bus.req_valid = 1'b0;
   endtask
   task automatic wait_rsp(input int max, output bit got);
      got = bus.rsp_valid;
      for (int i = 0; i < max && !got; i++) begin
         step();
         got = bus.rsp_valid;
      end
   endtask
   task automatic pop_one();
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.cfg_valid = 1'b0; bus.cfg_flush = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_mask = '0;
      bus.req_valid = 1'b1; bus.req_id = 4'd5; bus.rsp_ready = 1'b0;
      step(); step();
      chk("reset_cs", CS, 0);
      chk("reset_wr", WR, 0);
      chk("reset_req_ready", bus.req_ready, 0);
      chk("reset_rsp_valid", bus.rsp_valid, 0);
      bus.req_valid = 1'b0;
      rst_n = 1'b1;
      step();
      chk("run_cs", CS, 1);
      bus.cfg_valid = 1'b1; bus.cfg_addr = 4'd3; bus.cfg_data = 8'h5A; bus.cfg_mask = 8'hF0;
      #1;
      chk("wr_cfg_ready", bus.cfg_ready, 1);
      step();
      bus.cfg_valid = 1'b0;
      #1;
      chk("wr_WR", WR, 1);
      chk("wr_addr", Addr_In, 4'd3);
      chk("wr_data", Data_In, 8'h5A);
      chk("wr_mask", Mask_In, 8'hF0);
      chk("wr_vbe_vbi_dcs", {VBE, VBI, DCS}, 3'b111);
      chk("wr_cfg_ready_once", bus.cfg_ready, 0);
      step();
      chk("drain_WR", WR, 0);
      chk("drain_data", Data_In, 0);
      do_req(4'd5, 8, ok);
      chk("lk_accept", ok, 1);
      chk("lk_pid_cmp", PacketID_In, 4'd5);
      chk("lk_rv_1", bus.rsp_valid, 0);
      step();
      chk("lk_pid_rd", PacketID_In, 4'd5);
      chk("lk_rv_2", bus.rsp_valid, 0);
      step();
      chk("lk_rv_3", bus.rsp_valid, 0);
      step();
      chk("lk_rv_4", bus.rsp_valid, 1);
      chk("lk_dst", bus.rsp_dst, 4'hA);
      pop_one();
      chk("lk_popped", bus.rsp_valid, 0);
      do_req(4'd1, 8, ok);
      chk("b2b_acc1", ok, 1);
      do_req(4'd2, 4, ok);
      chk("b2b_acc2", ok, 1);
      do_req(4'd3, 8, ok);
      chk("b2b_full_refuse", ok, 0);
      chk("b2b_head", bus.rsp_dst, 4'h3);
      pop_one();
      do_req(4'd3, 8, ok);
      chk("b2b_acc3_after_pop", ok, 1);
      chk("b2b_head2", bus.rsp_dst, 4'h6);
      pop_one();
      wait_rsp(8, ok);
      chk("b2b_rsp3", ok, 1);
      chk("b2b_dst3", bus.rsp_dst, 4'h9);
      pop_one();
      step(); step();
      bus.cfg_valid = 1'b1; bus.cfg_flush = 1'b1; bus.req_valid = 1'b1; bus.req_id = 4'd7;
      #1;
      chk("pri_cfg_ready", bus.cfg_ready, 1);
      chk("pri_req_ready", bus.req_ready, 0);
      step();
      bus.cfg_valid = 1'b0; bus.cfg_flush = 1'b0;
      chk("pri_flush", FLUSH, 1);
      chk("pri_flush_wr", WR, 0);
      step();
      chk("pri_flush_drop", FLUSH, 0);
      do_req(4'd7, 8, ok);
      chk("pri_req_after", ok, 1);
      wait_rsp(8, ok);
      chk("miss_rsp", ok, 1);
      chk("miss_dst", bus.rsp_dst, 4'h0);
      pop_one();
      do_req(4'd2, 8, ok);
      chk("rst_acc", ok, 1);
      step();
      rst_n = 1'b0;
      #1;
      chk("rst_rv", bus.rsp_valid, 0);
      chk("rst_cs", CS, 0);
      chk("rst_pid", PacketID_In, 0);
      step();
      rst_n = 1'b1;
      wait_rsp(8, ok);
      chk("rst_no_rsp", ok, 0);
      bus.cfg_valid = 1'b1; bus.cfg_addr = 4'd9; bus.cfg_data = 8'h11; bus.cfg_mask = 8'h22;
      step();
      bus.cfg_valid = 1'b0;
      chk("rst_wr_pre", WR, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_wr_async", WR, 0);
      chk("rst_addr_async", Addr_In, 0);
      step();
      rst_n = 1'b1;
      step();
`ifdef TCAM_CTRL_STATS_EN
      bus.rsp_ready = 1'b1;
      do_req(4'd1, 8, ok);
      do_req(4'd7, 8, ok);
      do_req(4'd3, 8, ok);
      repeat (6) step();
      chk("stat_lookups", stat_lookups, 16'd3);
      chk("stat_miss", stat_miss, 16'd1);
      bus.rsp_ready = 1'b0;
      bus.cfg_valid = 1'b1; bus.cfg_flush = 1'b1;
      step();
      bus.cfg_valid = 1'b0; bus.cfg_flush = 1'b0;
      step();
      chk("stat_lookups_clr", stat_lookups, 16'd0);
      chk("stat_miss_clr", stat_miss, 16'd0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
